bip_control_unit: RTL and testbench

Instruction sequencer and decoder that sits directly upstream of the accumulator datapath in the TP3 BIP CPU. It owns the program counter and fetches 16-bit instructions from a synchronous program memory. It decodes each opcode into the datapath controls (operand, sel_a, sel_b, enb_acc, operation) and the data-RAM strobes, and runs a start/halt state machine.

---
 rtl/bip_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_bip_control_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// bip_control_unit
//   Instruction sequencer and decoder for the TP3 BIP CPU. Owns the program
//   counter, fetches instructions from a synchronous program memory and
//   decodes each opcode into accumulator-datapath controls and data-RAM
//   strobes. A start/halt state machine (IDLE -> FETCH <-> EXEC -> HALT)
//   sequences execution; only reset leaves HALT.
//
// Ports
//   i_clock        system clock, all state on rising edge
//   i_reset        synchronous, active-high reset
//   i_start        level; leaves IDLE when high
//   i_instruction  program-memory read data (valid the cycle after o_pc)
//   o_pc           program-memory address (registered PC)
//   o_data_addr    data-RAM address (instruction LSBs during EXEC)
//   o_operand      operand field to datapath (during EXEC)
//   o_sel_a        accumulator source: 00 RAM, 01 sign-ext operand, 10 adder
//   o_sel_b        adder B operand: 0 immediate, 1 RAM data
//   o_enb_acc      accumulator write enable
//   o_operation    1 ADD, 0 SUB
//   o_wr_ram       data-RAM write strobe (accumulator -> RAM)
//   o_rd_ram       data-RAM read strobe
//   o_halt         high while halted
//   o_instr_count  executed-instruction counter (saturating)
module bip_control_unit #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11,
    parameter int NB_OPCODE      = 5,
    parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
    parameter int NB_SELECTOR_A  = 2,
    parameter int NB_COUNT       = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_INSTRUCTION-1:0] i_instruction,
    output logic [NB_ADDR-1:0]        o_pc,
    output logic [NB_ADDR-1:0]        o_data_addr,
    output logic [NB_OPERAND-1:0]     o_operand,
    output logic [NB_SELECTOR_A-1:0]  o_sel_a,
    output logic                      o_sel_b,
    output logic                      o_enb_acc,
    output logic                      o_operation,
    output logic                      o_wr_ram,
    output logic                      o_rd_ram,
    output logic                      o_halt,
    output logic [NB_COUNT-1:0]       o_instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef enum logic [NB_OPCODE-1:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111
    } opcode_t;

    typedef enum logic [1:0] {
        SEL_A_RAM   = 2'b00,
        SEL_A_IMM   = 2'b01,
        SEL_A_ADDER = 2'b10,
        SEL_A_NONE  = 2'b11
    } sel_a_t;

    state_t                 state;
    state_t                 next_state;
    logic [NB_ADDR-1:0]     pc;
    logic [NB_COUNT-1:0]    count;
    logic [NB_OPCODE-1:0]   opcode;
    logic                   is_hlt;

    assign opcode = i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE];
    assign is_hlt = (opcode == OP_HLT);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            count <= '0;
        end else begin
            state <= next_state;
            if (state == ST_EXEC) begin
                // HLT is counted but leaves the PC on itself.
                if (!is_hlt) begin
                    pc <= pc + NB_ADDR'(1);
                end
                if (count != '1) begin
                    count <= count + NB_COUNT'(1);
                end
            end
        end
    end

    always_comb begin
        next_state  = state;
        o_data_addr = '0;
        o_operand   = '0;
        o_sel_a     = SEL_A_NONE;
        o_sel_b     = 1'b0;
        o_enb_acc   = 1'b0;
        o_operation = 1'b0;
        o_wr_ram    = 1'b0;
        o_rd_ram    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                next_state  = is_hlt ? ST_HALT : ST_FETCH;
                o_data_addr = i_instruction[NB_ADDR-1:0];
                o_operand   = i_instruction[NB_OPERAND-1:0];
                case (opcode)
                    OP_STO: begin
                        o_wr_ram = 1'b1;
                    end
                    OP_LD: begin
                        o_rd_ram  = 1'b1;
                        o_sel_a   = SEL_A_RAM;
                        o_enb_acc = 1'b1;
                    end
                    OP_LDI: begin
                        o_sel_a   = SEL_A_IMM;
                        o_enb_acc = 1'b1;
                    end
                    OP_ADD: begin
                        o_rd_ram    = 1'b1;
                        o_sel_a     = SEL_A_ADDER;
                        o_sel_b     = 1'b1;
                        o_operation = 1'b1;
                        o_enb_acc   = 1'b1;
                    end
                    OP_ADDI: begin
                        o_sel_a     = SEL_A_ADDER;
                        o_operation = 1'b1;
                        o_enb_acc   = 1'b1;
                    end
                    OP_SUB: begin
                        o_rd_ram  = 1'b1;
                        o_sel_a   = SEL_A_ADDER;
                        o_sel_b   = 1'b1;
                        o_enb_acc = 1'b1;
                    end
                    OP_SUBI: begin
                        o_sel_a   = SEL_A_ADDER;
                        o_enb_acc = 1'b1;
                    end
                    default: begin
                        // HLT and undefined opcodes drive no strobes.
                    end
                endcase
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign o_pc          = pc;
    assign o_halt        = (state == ST_HALT);
    assign o_instr_count = count;

endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit
//   Drives bip_control_unit from a synchronous program memory and a small
//   accumulator/data-RAM environment, and compares it against an
//   instruction-level model of the BIP ISA. The counter width is reduced so
//   that saturation is reached within the PC-wrap run.
module tb_bip_control_unit;

    localparam int NB_COUNT_TB = 8;
    localparam int CNT_MAX     = (1 << NB_COUNT_TB) - 1;
    localparam int MEM_WORDS   = 2048;

    logic                   i_clock = 1'b0;
    logic                   i_reset;
    logic                   i_start;
    logic [15:0]            i_instruction;
    logic [10:0]            o_pc;
    logic [10:0]            o_data_addr;
    logic [10:0]            o_operand;
    logic [1:0]             o_sel_a;
    logic                   o_sel_b;
    logic                   o_enb_acc;
    logic                   o_operation;
    logic                   o_wr_ram;
    logic                   o_rd_ram;
    logic                   o_halt;
    logic [NB_COUNT_TB-1:0] o_instr_count;

    bip_control_unit #(
        .NB_INSTRUCTION (16),
        .NB_ADDR        (11),
        .NB_OPCODE      (5),
        .NB_SELECTOR_A  (2),
        .NB_COUNT       (NB_COUNT_TB)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_instruction (i_instruction),
        .o_pc          (o_pc),
        .o_data_addr   (o_data_addr),
        .o_operand     (o_operand),
        .o_sel_a       (o_sel_a),
        .o_sel_b       (o_sel_b),
        .o_enb_acc     (o_enb_acc),
        .o_operation   (o_operation),
        .o_wr_ram      (o_wr_ram),
        .o_rd_ram      (o_rd_ram),
        .o_halt        (o_halt),
        .o_instr_count (o_instr_count)
    );

    always #5 i_clock = ~i_clock;

    logic [15:0] prog [MEM_WORDS];
    logic [15:0] dram [MEM_WORDS];
    logic [15:0] acc;

    always_ff @(posedge i_clock) i_instruction <= prog[o_pc];

    // Instruction-level reference state.
    logic [15:0] m_ram [MEM_WORDS];
    logic [15:0] m_acc;
    int          m_pc;
    int          m_cnt;
    bit          m_halted;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sext(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".wr"},   o_wr_ram,    1'b0);
        check({tag, ".rd"},   o_rd_ram,    1'b0);
        check({tag, ".en"},   o_enb_acc,   1'b0);
        check({tag, ".sela"}, o_sel_a,     2'b11);
        check({tag, ".selb"}, o_sel_b,     1'b0);
        check({tag, ".op"},   o_operation, 1'b0);
        check({tag, ".opnd"}, o_operand,   11'd0);
        check({tag, ".addr"}, o_data_addr, 11'd0);
    endtask

    task automatic clear_mem(input logic [15:0] fill);
        for (int i = 0; i < MEM_WORDS; i++) begin
            prog[i]  = fill;
            dram[i]  = '0;
            m_ram[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge i_clock);
        i_reset = 1'b1;
        i_start = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b0;
        acc     = '0;
        check("rst.pc",   o_pc,          11'd0);
        check("rst.cnt",  o_instr_count, '0);
        check("rst.halt", o_halt,        1'b0);
        check_quiet("rst");
    endtask

    // One EXEC cycle: check decode, apply datapath effect, advance the model.
    task automatic exec_step();
        logic [15:0] instr;
        logic [4:0]  op;
        logic [10:0] opr;
        logic [15:0] b;
        instr = prog[m_pc];
        op    = instr[15:11];
        opr   = instr[10:0];

        check("ex.halt", o_halt,      1'b0);
        check("ex.wr",   o_wr_ram,    (op == 5'd1));
        check("ex.rd",   o_rd_ram,    (op == 5'd2 || op == 5'd4 || op == 5'd6));
        check("ex.en",   o_enb_acc,   (op >= 5'd2 && op <= 5'd7));
        check("ex.addr", o_data_addr, opr);
        check("ex.opnd", o_operand,   opr);
        if (op == 5'd2) check("ex.sela", o_sel_a, 2'b00);
        if (op == 5'd3) check("ex.sela", o_sel_a, 2'b01);
        if (op >= 5'd4 && op <= 5'd7) begin
            check("ex.sela", o_sel_a,     2'b10);
            check("ex.selb", o_sel_b,     (op == 5'd4 || op == 5'd6));
            check("ex.op",   o_operation, (op == 5'd4 || op == 5'd5));
        end

        // Environment datapath, driven by what the DUT actually asserts.
        b = o_sel_b ? dram[o_data_addr] : sext(o_operand);
        if (o_wr_ram) dram[o_data_addr] = acc;
        if (o_enb_acc) begin
            case (o_sel_a)
                2'b00:   acc = dram[o_data_addr];
                2'b01:   acc = sext(o_operand);
                2'b10:   acc = o_operation ? acc + b : acc - b;
                default: acc = acc;
            endcase
        end

        // ISA model.
        case (op)
            5'd0: m_halted = 1'b1;
            5'd1: m_ram[opr] = m_acc;
            5'd2: m_acc = m_ram[opr];
            5'd3: m_acc = sext(opr);
            5'd4: m_acc = m_acc + m_ram[opr];
            5'd5: m_acc = m_acc + sext(opr);
            5'd6: m_acc = m_acc - m_ram[opr];
            5'd7: m_acc = m_acc - sext(opr);
            default: ;
        endcase
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        if (!m_halted) m_pc = (m_pc + 1) % MEM_WORDS;
    endtask

    // Starts the DUT from IDLE and runs up to max_exec instructions.
    task automatic run_prog(input int max_exec, input bit expect_halt);
        int n;
        int diffs;
        m_pc     = 0;
        m_cnt    = 0;
        m_halted = 1'b0;
        m_acc    = '0;
        n        = 0;
        i_start  = 1'b1;
        while (!m_halted && n < max_exec) begin
            @(negedge i_clock);
            i_start = 1'($urandom_range(0, 1));
            check("fe.pc",   o_pc,          m_pc[10:0]);
            check("fe.cnt",  o_instr_count, m_cnt);
            check("fe.halt", o_halt,        1'b0);
            check_quiet("fe");
            @(negedge i_clock);
            exec_step();
            i_start = 1'($urandom_range(0, 1));
            n++;
        end
        if (expect_halt) begin
            if (!m_halted) check("run.budget", 32'd0, 32'd1);
            @(negedge i_clock);
            check("ht.halt", o_halt,        1'b1);
            check("ht.pc",   o_pc,          m_pc[10:0]);
            check("ht.cnt",  o_instr_count, m_cnt);
            check_quiet("ht");
        end
        check("run.acc", acc, m_acc);
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (dram[i] !== m_ram[i]) diffs++;
        check("run.ram", diffs, 0);
        i_start = 1'b0;
    endtask

    initial begin
        i_reset = 1'b0;
        i_start = 1'b0;
        acc     = '0;
        clear_mem(16'h4000);

        // Reset, then a long idle with i_start low.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clock);
            check("idle.pc",   o_pc,   11'd0);
            check("idle.halt", o_halt, 1'b0);
            check_quiet("idle");
        end

        // LDI 5 / ADDI -2 / STO 3 / HLT.
        clear_mem(16'h4000);
        prog[0] = 16'h1805; prog[1] = 16'h2FFE; prog[2] = 16'h0803; prog[3] = 16'h0000;
        do_reset();
        run_prog(20, 1'b1);
        check("p1.ram3", dram[3],       16'h0003);
        check("p1.pc",   o_pc,          11'd3);
        check("p1.cnt",  o_instr_count, 8'd4);

        // LD 7 / SUB 8 / HLT.
        clear_mem(16'h4000);
        prog[0] = 16'h1007; prog[1] = 16'h3008; prog[2] = 16'h0000;
        dram[7] = 16'h0010; m_ram[7] = 16'h0010;
        dram[8] = 16'h0011; m_ram[8] = 16'h0011;
        do_reset();
        run_prog(20, 1'b1);
        check("p2.acc", acc, 16'hFFFF);

        // Undefined opcode followed by HLT.
        clear_mem(16'h4000);
        prog[0] = 16'hF800; prog[1] = 16'h0000;
        do_reset();
        run_prog(20, 1'b1);
        check("p3.pc",  o_pc,          11'd1);
        check("p3.cnt", o_instr_count, 8'd2);

        // Reset asserted during EXEC of an ADD.
        clear_mem(16'h4000);
        prog[0] = 16'h1801; prog[1] = 16'h2000;
        do_reset();
        i_start = 1'b1;
        repeat (4) @(negedge i_clock);
        check("mid.en_pre",  o_enb_acc,     1'b1);
        check("mid.cnt_pre", o_instr_count, 8'd1);
        i_reset = 1'b1;
        i_start = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b0;
        check("mid.pc",   o_pc,          11'd0);
        check("mid.cnt",  o_instr_count, '0);
        check("mid.halt", o_halt,        1'b0);
        check_quiet("mid");
        @(negedge i_clock);
        check("mid.idle_pc", o_pc, 11'd0);
        check_quiet("mid.idle");

        // All-NOP program: PC wraps 2047 -> 0 and the counter saturates.
        clear_mem(16'h4000);
        do_reset();
        run_prog(MEM_WORDS + 1, 1'b0);
        @(negedge i_clock);
        check("wrap.pc",  o_pc,          11'd1);
        check("wrap.cnt", o_instr_count, 8'hFF);

        // HALT ignores i_start.
        clear_mem(16'h4000);
        prog[0] = 16'h1801; prog[1] = 16'h0000;
        do_reset();
        run_prog(20, 1'b1);
        for (int i = 0; i < 6; i++) begin
            i_start = ~i_start;
            @(negedge i_clock);
            check("hs.halt", o_halt,        1'b1);
            check("hs.pc",   o_pc,          11'd1);
            check("hs.cnt",  o_instr_count, 8'd2);
            check_quiet("hs");
        end
        i_start = 1'b0;

        // Random programs.
        for (int t = 0; t < 25; t++) begin
            int len;
            clear_mem(16'h4000);
            for (int a = 0; a < 16; a++) begin
                dram[a]  = 16'($urandom);
                m_ram[a] = dram[a];
            end
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                logic [4:0]  op;
                logic [10:0] opr;
                op = 5'($urandom_range(1, 9));
                if (op >= 5'd8) op = 5'($urandom_range(8, 31));
                if (op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd6)
                    opr = 11'($urandom_range(0, 15));
                else
                    opr = 11'($urandom);
                prog[k] = {op, opr};
            end
            prog[len] = 16'h0000;
            do_reset();
            run_prog(20, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
